one_hot_rr_arbiter: RTL and testbench
=====================================

ONE_HOT_RR_ARBITER -- requirements
Module: one_hot_rr_arbiter

Interface
REQ-001 Parameter bus_count, default 4, number of requesters; legal range 2..32.
REQ-002 Parameter timeout_cycles, default 16, grant watchdog limit in cycles; legal range 2..65535; used only under REQ-024.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  bus_count  per-requester request, level-sensitive.
REQ-006 Port done  input  1  grantee finished; one-cycle pulse or level, sampled only in GRANT.
REQ-007 Port grant  output  bus_count  registered one-hot grant; drives the downstream one-hot mux select directly.
REQ-008 Port grant_valid  output  1  high when grant is non-zero.
REQ-009 Port grant_idx  output  clog2(bus_count)  binary index of the current grantee; 0 when grant_valid is low.
REQ-010 Port timeout  output  1  one-cycle pulse on watchdog release.

Function
REQ-011 The block SHALL implement two states, IDLE and GRANT.
REQ-012 In IDLE with req all-zero, the block SHALL stay in IDLE with grant = 0.
REQ-013 In IDLE with any req bit set, the block SHALL select the first set bit searching upward from pointer ptr and wrapping from bus_count-1 to 0, and SHALL assert the matching grant bit on the next edge while entering GRANT (latency 1 cycle from req to grant).
REQ-014 grant SHALL never have more than one bit set, in any cycle, under any input.
REQ-015 In GRANT, grant, grant_idx and grant_valid SHALL stay constant while done is low, regardless of req changes, including deassertion of the grantee's own req.
REQ-016 In GRANT with done high, the block SHALL clear grant on the next edge, set ptr to (grant_idx+1) mod bus_count, and return to IDLE.
REQ-017 At least one cycle with grant = 0 SHALL separate consecutive grants (back-to-back arbitration not permitted).
REQ-018 done high in IDLE SHALL be ignored.
REQ-019 done and new req bits arriving in the same GRANT cycle: release per REQ-016; the new req bits are arbitrated in the following IDLE cycle using the updated ptr.
REQ-020 With all req bits held high continuously, successive grants SHALL rotate 0,1,...,bus_count-1,0,...

Reset
REQ-021 rst_n low SHALL asynchronously force state IDLE, grant = 0, grant_valid = 0, grant_idx = 0, timeout = 0, ptr = 0, watchdog count = 0.
REQ-022 Reset asserted mid-GRANT SHALL drop grant immediately without waiting for a clock edge; no timeout pulse is generated.
REQ-023 After rst_n deasserts, the first arbitration SHALL start its search at index 0.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to GRANT, increment each GRANT cycle with done low, and on reaching timeout_cycles SHALL release the grant exactly as REQ-016 while pulsing timeout high for that same release cycle.
REQ-025 With ARB_TIMEOUT_EN undefined, no counter SHALL be built, timeout SHALL be tied 0, and grant SHALL be held indefinitely until done.
REQ-026 done arriving in the cycle the count reaches timeout_cycles SHALL release normally with timeout = 0.

Verification (bus_count = 4, timeout_cycles = 16)
REQ-027 Reset, then req = 4'b0100 -> grant = 4'b0100, grant_idx = 2 one cycle later; done pulse -> grant = 0 next cycle, ptr = 3.
REQ-028 req = 4'b1111 held, done pulsed 2 cycles after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with a zero-grant cycle between each.
REQ-029 With ptr = 3, req = 4'b0011 -> grant = 4'b0001 (wrap-around search).
REQ-030 Grant to index 1, then req[1] dropped and req[3] raised with done low for 5 cycles -> grant stays 4'b0010 throughout.
REQ-031 ARB_TIMEOUT_EN defined, grant to index 0, done never asserted -> grant clears on the 16th GRANT cycle edge with timeout high for exactly one cycle; macro undefined -> grant held for 100 cycles, timeout stays 0.
REQ-032 rst_n pulsed low mid-GRANT between clock edges -> grant = 0 immediately; next req = 4'b1010 -> grant = 4'b0010.

Source files
------------

// File: rtl/one_hot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, held until done; optional
// grant watchdog built only when ARB_TIMEOUT_EN is defined.
module one_hot_rr_arbiter #(
  parameter int bus_count      = 4,
  parameter int timeout_cycles = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [bus_count-1:0]         req,
  input  logic                         done,
  output logic [bus_count-1:0]         grant,
  output logic                         grant_valid,
  output logic [$clog2(bus_count)-1:0] grant_idx,
  output logic                         timeout
);

  localparam int IDXW = $clog2(bus_count);
  localparam int CW   = IDXW + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(bus_count - 1);

  if (bus_count < 2 || bus_count > 32) begin : g_bad_bus_count
    $error("one_hot_rr_arbiter: bus_count must be 2..32");
  end
  if (timeout_cycles < 2 || timeout_cycles > 65535) begin : g_bad_timeout
    $error("one_hot_rr_arbiter: timeout_cycles must be 2..65535");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [bus_count-1:0]  grant_q, grant_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [IDXW-1:0]       grant_idx_q, grant_idx_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(timeout_cycles);
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
`endif

  // Rotating-priority search: first set req bit at or above ptr, wrapping to 0.
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic [CW-1:0]   cand;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < bus_count; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(bus_count)) begin
        cand = cand - CW'(bus_count);
      end
      if (!win_found && req[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

  logic release_grant;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    release_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // done is meaningless here; only req is looked at.
        if (win_found) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_valid_d    = 1'b1;
          grant_idx_d      = win_idx;
`ifdef ARB_TIMEOUT_EN
          wd_d             = '0;
`endif
        end
      end
      GRANT: begin
        release_grant = done;
`ifdef ARB_TIMEOUT_EN
        // A done on the limit cycle wins, so that release is not a timeout.
        if (!done) begin
          wd_d = wd_q + 16'd1;
          if (wd_d == WD_LIMIT) begin
            release_grant = 1'b1;
            timeout_d     = 1'b1;
          end
        end
`endif
        if (release_grant) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          ptr_d         = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      ptr_q         <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_q          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      ptr_q         <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_one_hot_rr_arbiter.sv
// Directed bench for one_hot_rr_arbiter (bus_count=4, timeout_cycles=16).
module tb_one_hot_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       timeout;

  int checks;
  int errors;

  one_hot_rr_arbiter #(.bus_count(4), .timeout_cycles(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs packed as {grant_valid, grant_idx, grant}.
  function automatic logic [6:0] obs();
    return {grant_valid, grant_idx, grant};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = 1'b0;
    #2;
    checks++;
    if (obs() !== 7'b0_00_0000) begin
      errors++; $display("FAIL reset_outputs got %b want %b", obs(), 7'b0_00_0000);
    end
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout got %b want 0", timeout);
    end
    tick();
    rst_n = 1'b1; req = 4'b0000;
    tick();
  endtask

  task automatic test_single_and_wrap();
    req = 4'b0100;
    tick();
    checks++;
    if (obs() !== 7'b1_10_0100) begin
      errors++; $display("FAIL single_grant got %b want %b", obs(), 7'b1_10_0100);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (obs() !== 7'b0_00_0000) begin
      errors++; $display("FAIL single_release got %b want %b", obs(), 7'b0_00_0000);
    end
    // ptr now 3: 3 is idle so the search wraps to 0.
    req = 4'b0011;
    tick();
    checks++;
    if (obs() !== 7'b1_00_0001) begin
      errors++; $display("FAIL wrap_grant got %b want %b", obs(), 7'b1_00_0001);
    end
    done = 1'b1; req = 4'b0000;
    tick();
    done = 1'b0;
    checks++;
    if (obs() !== 7'b0_00_0000) begin
      errors++; $display("FAIL wrap_release got %b want %b", obs(), 7'b0_00_0000);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_seq [5];
    logic [1:0] exp_idx [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if (obs() !== {1'b1, exp_idx[g], exp_seq[g]}) begin
        errors++; $display("FAIL rotate_grant%0d got %b want %b", g, obs(), {1'b1, exp_idx[g], exp_seq[g]});
      end
      tick();
      checks++;
      if (grant !== exp_seq[g]) begin
        errors++; $display("FAIL rotate_hold%0d got %b want %b", g, grant, exp_seq[g]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (obs() !== 7'b0_00_0000) begin
        errors++; $display("FAIL rotate_gap%0d got %b want %b", g, obs(), 7'b0_00_0000);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_hold_and_same_cycle();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs() !== 7'b1_01_0010) begin
        errors++; $display("FAIL hold_cycle%0d got %b want %b", c, obs(), 7'b1_01_0010);
      end
    end
    // Release and new request together: arbitrated after the gap with ptr=2.
    done = 1'b1; req = 4'b1001;
    tick();
    done = 1'b0;
    checks++;
    if (obs() !== 7'b0_00_0000) begin
      errors++; $display("FAIL same_cycle_gap got %b want %b", obs(), 7'b0_00_0000);
    end
    tick();
    checks++;
    if (obs() !== 7'b1_11_1000) begin
      errors++; $display("FAIL same_cycle_grant got %b want %b", obs(), 7'b1_11_1000);
    end
    done = 1'b1; req = 4'b0000;
    tick();
    done = 1'b0;
  endtask

  task automatic test_done_in_idle();
    do_reset();
    done = 1'b1;
    tick();
    tick();
    done = 1'b0;
    checks++;
    if (obs() !== 7'b0_00_0000) begin
      errors++; $display("FAIL idle_done got %b want %b", obs(), 7'b0_00_0000);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (obs() !== 7'b1_00_0001) begin
      errors++; $display("FAIL idle_done_grant got %b want %b", obs(), 7'b1_00_0001);
    end
    done = 1'b1; req = 4'b0000;
    tick();
    done = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
        errors++; $display("FAIL wd_hold%0d grant %b timeout %b want 0001 0", c, grant, timeout);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1) begin
      errors++; $display("FAIL wd_release grant %b timeout %b want 0000 1", grant, timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL wd_pulse_width timeout %b want 0", timeout);
    end
    // done on the limit cycle: ordinary release, no timeout pulse.
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int c = 1; c <= 15; c++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      errors++; $display("FAIL wd_done_race grant %b timeout %b want 0000 0", grant, timeout);
    end
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
        errors++; $display("FAIL no_wd_hold%0d grant %b timeout %b want 0001 0", c, grant, timeout);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL areset_pre got %b want 0001", grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b0_00_0000 || timeout !== 1'b0) begin
      errors++; $display("FAIL areset_drop got %b timeout %b want %b 0", obs(), timeout, 7'b0_00_0000);
    end
    req = 4'b1010;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs() !== 7'b1_01_0010) begin
      errors++; $display("FAIL areset_regrant got %b want %b", obs(), 7'b1_01_0010);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    done   = 1'b0;
    test_reset();
    test_single_and_wrap();
    test_rotate();
    test_hold_and_same_cycle();
    test_done_in_idle();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
